// File: rtl/data_island_packet_assembler.sv
// HDMI data-island packet serializer: header + four subpackets plus BCH parity, 9 bits per pixel.
// Latency one pixel clock; no backpressure, the fixed 32-pixel cadence is set by packet_enable.
module data_island_packet_assembler (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             data_island_start,
    input  logic             data_island_period,
    input  logic [23:0]      header,
    input  logic [3:0][55:0] sub,
    output logic             packet_enable,
    output logic [4:0]       packet_pixel_counter,
    output logic [8:0]       packet_data,
    output logic             packet_data_valid,
    output logic             packet_first
);

    // BCH generator x^8+x^7+x^6+1, data consumed LSB first
    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        return (e >> 1) ^ (((e[0] ^ b) == 1'b1) ? 8'h83 : 8'h00);
    endfunction

    logic [4:0]       counter_q, counter_d;
    logic [23:0]      hdr_shadow_q, hdr_shadow_d;
    logic [3:0][55:0] sub_shadow_q, sub_shadow_d;
    logic [7:0]       h_ecc_q, h_ecc_d;
    logic [3:0][7:0]  s_ecc_q, s_ecc_d;
    logic [8:0]       data_q, data_d;
    logic             valid_q;
    logic             first_q;

    logic             first_pixel;
    logic [23:0]      hdr_cur;
    logic [3:0][55:0] sub_cur;
    logic [7:0]       h_seed;
    logic [3:0][7:0]  s_seed;
    logic             hdr_bit;
    logic [3:0]       sub_lo;
    logic [3:0]       sub_hi;

    assign first_pixel = (counter_q == 5'd0);

    // Pixel 0 reads the live inputs; later pixels read the copy taken at pixel 0.
    assign hdr_cur = first_pixel ? header : hdr_shadow_q;
    assign sub_cur = first_pixel ? sub : sub_shadow_q;

    always_comb begin
        counter_d    = data_island_period ? counter_q + 5'd1 : 5'd0;
        hdr_shadow_d = hdr_shadow_q;
        sub_shadow_d = sub_shadow_q;
        h_ecc_d      = h_ecc_q;
        s_ecc_d      = s_ecc_q;
        hdr_bit      = 1'b0;
        sub_lo       = 4'd0;
        sub_hi       = 4'd0;
        data_d       = 9'd0;
        h_seed       = first_pixel ? 8'h00 : h_ecc_q;
        for (int k = 0; k < 4; k++) begin
            s_seed[k] = first_pixel ? 8'h00 : s_ecc_q[k];
        end

        if (data_island_period) begin
            if (first_pixel) begin
                hdr_shadow_d = header;
                sub_shadow_d = sub;
            end

            if (counter_q < 5'd24) begin
                hdr_bit = hdr_cur[counter_q];
                h_ecc_d = ecc_step(h_seed, hdr_bit);
            end else begin
                hdr_bit = h_ecc_q[counter_q[2:0]];
            end

            for (int k = 0; k < 4; k++) begin
                if (counter_q < 5'd28) begin
                    sub_lo[k]  = sub_cur[k][{counter_q, 1'b0}];
                    sub_hi[k]  = sub_cur[k][{counter_q, 1'b1}];
                    s_ecc_d[k] = ecc_step(ecc_step(s_seed[k], sub_lo[k]), sub_hi[k]);
                end else begin
                    sub_lo[k] = s_ecc_q[k][{counter_q[1:0], 1'b0}];
                    sub_hi[k] = s_ecc_q[k][{counter_q[1:0], 1'b1}];
                end
            end

            data_d = {sub_hi, sub_lo, hdr_bit};
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            counter_q    <= 5'd0;
            hdr_shadow_q <= '0;
            sub_shadow_q <= '0;
            h_ecc_q      <= 8'h00;
            s_ecc_q      <= '0;
            data_q       <= 9'd0;
            valid_q      <= 1'b0;
            first_q      <= 1'b0;
        end else begin
            counter_q    <= counter_d;
            hdr_shadow_q <= hdr_shadow_d;
            sub_shadow_q <= sub_shadow_d;
            h_ecc_q      <= h_ecc_d;
            s_ecc_q      <= s_ecc_d;
            data_q       <= data_d;
            valid_q      <= data_island_period;
            first_q      <= data_island_period & first_pixel;
        end
    end

    // Tells the picker to register its next packet choice; start is ignored inside an island.
    assign packet_enable = (data_island_start & ~data_island_period)
                         | (data_island_period & (counter_q == 5'd31));

    assign packet_pixel_counter = counter_q;
    assign packet_data          = data_q;
    assign packet_data_valid    = valid_q;
    assign packet_first         = first_q;

endmodule
